// File: rtl/eth_tx_frame_fifo_if.sv
// AXI4-Stream beat bundle for the MAC-side frame FIFO.
// The master drives the beat fields and the slave drives tready.
interface eth_tx_frame_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward frame FIFO ahead of the GMII transmit MAC. A frame becomes readable only
// after its last beat commits. Bad and oversize frames are dropped, and each drop is reported.
module eth_tx_frame_fifo #(
   parameter int unsigned DEPTH          = 4096,
   parameter bit          DROP_BAD_FRAME = 1'b1,
   parameter int unsigned DATA_WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   eth_tx_frame_fifo_if.slave   s_axis,
   eth_tx_frame_fifo_if.master  m_axis,
   output logic                 status_overflow,
   output logic                 status_bad_frame,
   output logic                 status_good_frame
);
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

   typedef logic [ADDR_WIDTH:0] ptr_t;
   localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);

   // Entry layout: {tlast, tuser, tdata}
   logic [DATA_WIDTH+1:0] mem [DEPTH];

   ptr_t wr_commit_q, wr_commit_d;
   ptr_t wr_cur_q, wr_cur_d;
   ptr_t rd_ptr_q;
   logic drop_q, drop_d;
   logic in_ready_q;
   logic ovf_d, bad_d, good_d;
   logic ovf_q, bad_q, good_q;
   logic mem_we;
   logic accept, full_cur, empty, load;

   logic                  out_valid_q;
   logic                  out_last_q;
   logic                  out_user_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   assign accept   = s_axis.tvalid & in_ready_q;
   // rd_ptr is the value from the start of the cycle, so a same-cycle read earns no credit.
   assign full_cur = ((wr_cur_q - rd_ptr_q) == DEPTH_PTR);
   assign empty    = (rd_ptr_q == wr_commit_q);
   assign load     = !empty && (!out_valid_q || m_axis.tready);

   always_comb begin
      wr_cur_d    = wr_cur_q;
      wr_commit_d = wr_commit_q;
      drop_d      = drop_q;
      ovf_d       = 1'b0;
      bad_d       = 1'b0;
      good_d      = 1'b0;
      mem_we      = 1'b0;
      if (accept) begin
         if (drop_q) begin
            if (s_axis.tlast) begin
               drop_d = 1'b0;
            end
         end else if (full_cur) begin
            wr_cur_d = wr_commit_q;
            ovf_d    = 1'b1;
            drop_d   = !s_axis.tlast;
         end else begin
            mem_we   = 1'b1;
            wr_cur_d = wr_cur_q + 1'b1;
            if (s_axis.tlast) begin
               if (DROP_BAD_FRAME && s_axis.tuser) begin
                  wr_cur_d = wr_commit_q;
                  bad_d    = 1'b1;
               end else begin
                  wr_commit_d = wr_cur_q + 1'b1;
                  good_d      = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cur_q    <= '0;
         wr_commit_q <= '0;
         drop_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         ovf_q       <= 1'b0;
         bad_q       <= 1'b0;
         good_q      <= 1'b0;
      end else begin
         wr_cur_q    <= wr_cur_d;
         wr_commit_q <= wr_commit_d;
         drop_q      <= drop_d;
         in_ready_q  <= 1'b1;
         ovf_q       <= ovf_d;
         bad_q       <= bad_d;
         good_q      <= good_d;
      end
   end

   // tuser is only meaningful on the last beat, so it is stored as zero elsewhere.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_cur_q[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tlast & s_axis.tuser,
                                           s_axis.tdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (load) begin
         {out_last_q, out_user_q, out_data_q} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         rd_ptr_q    <= rd_ptr_q + 1'b1;
         out_valid_q <= 1'b1;
      end else if (m_axis.tready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign s_axis.tready     = in_ready_q;
   assign m_axis.tvalid     = out_valid_q;
   assign m_axis.tlast      = out_last_q;
   assign m_axis.tuser      = out_user_q;
   assign m_axis.tdata      = out_data_q;
   assign status_overflow   = ovf_q;
   assign status_bad_frame  = bad_q;
   assign status_good_frame = good_q;
endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Bench for eth_tx_frame_fifo: two instances (bad frames dropped / forwarded) share stimulus,
// and each instance has its own queue of expected beats.
module tb_eth_tx_frame_fifo;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eth_tx_frame_fifo_if #(.DATA_WIDTH(8)) s0 ();
   eth_tx_frame_fifo_if #(.DATA_WIDTH(8)) s1 ();
   eth_tx_frame_fifo_if #(.DATA_WIDTH(8)) m0 ();
   eth_tx_frame_fifo_if #(.DATA_WIDTH(8)) m1 ();

   logic st_ovf0, st_bad0, st_good0;
   logic st_ovf1, st_bad1, st_good1;

   assign s1.tdata  = s0.tdata;
   assign s1.tvalid = s0.tvalid;
   assign s1.tlast  = s0.tlast;
   assign s1.tuser  = s0.tuser;
   assign m1.tready = m0.tready;

   eth_tx_frame_fifo #(.DEPTH(DEPTH), .DROP_BAD_FRAME(1'b1), .DATA_WIDTH(8)) u_dut0 (
      .clk              (clk),
      .rst              (rst),
      .s_axis           (s0),
      .m_axis           (m0),
      .status_overflow  (st_ovf0),
      .status_bad_frame (st_bad0),
      .status_good_frame(st_good0)
   );

   eth_tx_frame_fifo #(.DEPTH(DEPTH), .DROP_BAD_FRAME(1'b0), .DATA_WIDTH(8)) u_dut1 (
      .clk              (clk),
      .rst              (rst),
      .s_axis           (s1),
      .m_axis           (m1),
      .status_overflow  (st_ovf1),
      .status_bad_frame (st_bad1),
      .status_good_frame(st_good1)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [9:0] q0[$];
   logic [9:0] q1[$];
   int eg0 = 0, eb0 = 0, eo0 = 0, eg1 = 0, eb1 = 0, eo1 = 0;
   int ag0 = 0, ab0 = 0, ao0 = 0, ag1 = 0, ab1 = 0, ao1 = 0;

   bit         in_frame[2];
   bit         held[2];
   logic [9:0] held_val[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: in-order data, no tvalid gap inside a frame, hold while stalled.
   task automatic mon(input int id, input logic v, input logic r, input logic l,
                      input logic u, input logic [7:0] d);
      logic [9:0] cur;
      logic [9:0] e;
      int         sz;
      cur = {l, u, d};
      if (rst) begin
         in_frame[id] = 1'b0;
         held[id]     = 1'b0;
         return;
      end
      if (held[id]) begin
         chk($sformatf("dut%0d_hold_valid", id), v, 1);
         chk($sformatf("dut%0d_hold_beat", id), cur, held_val[id]);
      end
      if (in_frame[id]) chk($sformatf("dut%0d_no_gap", id), v, 1);
      held[id]     = v && !r;
      held_val[id] = cur;
      if (v && r) begin
         sz = (id == 0) ? q0.size() : q1.size();
         chk($sformatf("dut%0d_beat_expected", id), (sz != 0), 1);
         if (sz != 0) begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d_beat", id), cur, e);
         end
         in_frame[id] = !l;
      end
   endtask

   always @(negedge clk) mon(0, m0.tvalid, m0.tready, m0.tlast, m0.tuser, m0.tdata);
   always @(negedge clk) mon(1, m1.tvalid, m1.tready, m1.tlast, m1.tuser, m1.tdata);

   always @(negedge clk) begin
      if (!rst) begin
         ag0 += int'(st_good0);
         ab0 += int'(st_bad0);
         ao0 += int'(st_ovf0);
         ag1 += int'(st_good1);
         ab1 += int'(st_bad1);
         ao1 += int'(st_ovf1);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected outcome of one frame sent into an otherwise drained FIFO.
   task automatic expect_frame(input int len, input logic [7:0] start, input bit bad);
      logic       last;
      logic [7:0] d;
      if (len > int'(DEPTH)) begin
         eo0++;
         eo1++;
      end else begin
         for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            d    = 8'(start + i);
            if (!bad) q0.push_back({last, 1'b0, d});
            q1.push_back({last, last & bad, d});
         end
         if (bad) eb0++;
         else eg0++;
         eg1++;
      end
   endtask

   task automatic send_frame(input int len, input logic [7:0] start, input bit bad,
                             input int stall_at, input int gap);
      expect_frame(len, start, bad);
      for (int i = 0; i < len; i++) begin
         if (i == stall_at) begin
            s0.tvalid = 1'b0;
            repeat (gap) begin
               @(posedge clk);
               #1;
               chk("no_output_before_tlast", m0.tvalid, 0);
            end
         end
         s0.tvalid = 1'b1;
         s0.tdata  = 8'(start + i);
         s0.tlast  = (i == len - 1);
         s0.tuser  = (i == len - 1) && bad;
         @(posedge clk);
         #1;
      end
      s0.tvalid = 1'b0;
      s0.tlast  = 1'b0;
      s0.tuser  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("drain_in_time", (n < 400), 1);
      idle(3);
      chk("idle_after_drain0", m0.tvalid, 0);
      chk("idle_after_drain1", m1.tvalid, 0);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_good0"}, ag0, eg0);
      chk({tag, "_bad0"}, ab0, eb0);
      chk({tag, "_ovf0"}, ao0, eo0);
      chk({tag, "_good1"}, ag1, eg1);
      chk({tag, "_bad1"}, ab1, eb1);
      chk({tag, "_ovf1"}, ao1, eo1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  found;
      s0.tvalid = 1'b0;
      s0.tdata  = '0;
      s0.tlast  = 1'b0;
      s0.tuser  = 1'b0;
      m0.tready = 1'b1;
      rst       = 1'b1;
      idle(3);
      chk("rst_s_tready", s0.tready, 0);
      chk("rst_m_tvalid", m0.tvalid, 0);
      chk("rst_m_tlast", m0.tlast, 0);
      chk("rst_m_tuser", m0.tuser, 0);
      chk("rst_m_tdata", m0.tdata, 0);
      chk("rst_status", {st_ovf0, st_bad0, st_good0, st_ovf1, st_bad1, st_good1}, 0);
      rst = 1'b0;
      idle(1);
      chk("post_rst_s_tready", s0.tready, 1);

      // Basic frame and output latency
      send_frame(10, 8'h01, 1'b0, -1, 0);
      chk("latency_edge_e", m0.tvalid, 0);
      idle(1);
      chk("latency_edge_e1_valid", m0.tvalid, 1);
      chk("latency_edge_e1_data", m0.tdata, 8'h01);
      wait_drain();
      check_status("basic");

      // Input stall mid-frame
      send_frame(10, 8'h10, 1'b0, 4, 5);
      wait_drain();
      check_status("stall");

      // Bad frame followed by good frame
      send_frame(8, 8'h20, 1'b1, -1, 0);
      send_frame(6, 8'h30, 1'b0, -1, 0);
      wait_drain();
      check_status("bad");

      // Oversize frame dropped, then a small frame and an exactly-full frame
      send_frame(20, 8'hA0, 1'b0, -1, 0);
      send_frame(4, 8'hC0, 1'b0, -1, 0);
      wait_drain();
      send_frame(16, 8'hD0, 1'b0, -1, 0);
      wait_drain();
      check_status("oversize");

      // Three frames under a toggling tready, wrapping the pointers
      fork
         begin
            send_frame(7, 8'h60, 1'b0, -1, 0);
            idle(3);
            send_frame(7, 8'h70, 1'b0, -1, 0);
            idle(3);
            send_frame(7, 8'h80, 1'b0, -1, 0);
         end
         begin
            repeat (60) begin
               @(posedge clk);
               #1;
               m0.tready = ~m0.tready;
            end
         end
      join
      m0.tready = 1'b1;
      wait_drain();
      check_status("toggle");

      // Reset while beat 3 of 10 is on the output
      send_frame(10, 8'h40, 1'b0, -1, 0);
      found = 1'b0;
      n     = 0;
      while (!found && n < 50) begin
         @(posedge clk);
         #1;
         n++;
         found = m0.tvalid && (m0.tdata == 8'h42);
      end
      chk("beat3_seen", found, 1);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      idle(1);
      chk("mid_rst_m_tvalid0", m0.tvalid, 0);
      chk("mid_rst_m_tvalid1", m1.tvalid, 0);
      rst = 1'b0;
      idle(1);
      chk("mid_rst_s_tready", s0.tready, 1);
      send_frame(5, 8'h50, 1'b0, -1, 0);
      wait_drain();
      check_status("reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
